// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg : shared types for the two-host RAM arbiter.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ram_arb_pkg;

   typedef enum logic {
      HOST_CORE   = 1'b0,
      HOST_LOADER = 1'b1
   } host_e;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } ram_req_t;

   localparam int unsigned BurstCntW = 4;

endpackage : ram_arb_pkg

`default_nettype wire

// File: rtl/ram_arb_sched.sv
// ---------------------------------------------------------------------------
// ram_arb_sched : burst-limited round-robin winner selection.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_arb_sched
   import ram_arb_pkg::*;
#(
   parameter int unsigned MaxBurst = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   output logic       valid_o,
   output host_e      winner_o
);

   localparam logic [BurstCntW-1:0] MAX_CNT = BurstCntW'(MaxBurst);

   host_e                prio_q, prio_d;
   host_e                last_q, last_d;
   logic [BurstCntW-1:0] cnt_q, cnt_d;

   always_comb begin
      valid_o  = |req_i;
      winner_o = HOST_CORE;
      case (req_i)
         2'b01:   winner_o = HOST_CORE;
         2'b10:   winner_o = HOST_LOADER;
         2'b11:   winner_o = prio_q;
         default: winner_o = HOST_CORE;
      endcase
   end

   // The winner's run length decides whether priority hands over.
   always_comb begin
      cnt_d  = cnt_q;
      last_d = last_q;
      prio_d = prio_q;
      if (valid_o) begin
         if (winner_o == last_q) begin
            cnt_d = (cnt_q >= MAX_CNT) ? MAX_CNT : cnt_q + 4'd1;
         end else begin
            cnt_d = 4'd1;
         end
         last_d = winner_o;
         prio_d = (cnt_d == MAX_CNT) ? host_e'(~winner_o) : winner_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio_q <= HOST_CORE;
         last_q <= HOST_CORE;
         cnt_q  <= '0;
      end else begin
         prio_q <= prio_d;
         last_q <= last_d;
         cnt_q  <= cnt_d;
      end
   end

   a_burst_range: assert property (@(posedge clk_i)
      (MaxBurst >= 1) && (MaxBurst <= 15));

endmodule : ram_arb_sched

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter : shares one RAM port between core and loader hosts.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned Depth    = 16384,
   parameter int unsigned MaxBurst = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        host0_req_i,
   input  logic        host0_we_i,
   input  logic [3:0]  host0_be_i,
   input  logic [31:0] host0_addr_i,
   input  logic [31:0] host0_wdata_i,
   output logic        host0_gnt_o,
   output logic        host0_rvalid_o,
   output logic [31:0] host0_rdata_o,
   output logic        host0_err_o,

   input  logic        host1_req_i,
   input  logic        host1_we_i,
   input  logic [3:0]  host1_be_i,
   input  logic [31:0] host1_addr_i,
   input  logic [31:0] host1_wdata_i,
   output logic        host1_gnt_o,
   output logic        host1_rvalid_o,
   output logic [31:0] host1_rdata_o,
   output logic        host1_err_o,

   output logic        ram_req_o,
   output logic        ram_we_o,
   output logic [3:0]  ram_be_o,
   output logic [31:0] ram_addr_o,
   output logic [31:0] ram_wdata_o,
   input  logic [31:0] ram_rdata_i
);

   localparam logic [32:0] ADDR_LIMIT = 33'(Depth) << 2;

   logic     sched_valid;
   host_e    sched_winner;
   logic     gnt_valid;
   logic     in_range;
   ram_req_t host0_req, host1_req, sel_req;

   logic     rsp_valid_q;
   host_e    rsp_host_q;
   logic     rsp_err_q;
   logic     we_q;

   ram_arb_sched #(
      .MaxBurst (MaxBurst)
   ) u_sched (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    ({host1_req_i, host0_req_i}),
      .valid_o  (sched_valid),
      .winner_o (sched_winner)
   );

   assign host0_req = '{we: host0_we_i, be: host0_be_i, addr: host0_addr_i, wdata: host0_wdata_i};
   assign host1_req = '{we: host1_we_i, be: host1_be_i, addr: host1_addr_i, wdata: host1_wdata_i};

   always_comb begin
      gnt_valid   = sched_valid & ~rst_i;
      sel_req     = (sched_winner == HOST_LOADER) ? host1_req : host0_req;
      in_range    = {1'b0, sel_req.addr[31:2], 2'b00} < ADDR_LIMIT;
      host0_gnt_o = gnt_valid && (sched_winner == HOST_CORE);
      host1_gnt_o = gnt_valid && (sched_winner == HOST_LOADER);
      ram_req_o   = 1'b0;
      ram_we_o    = 1'b0;
      ram_be_o    = '0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      if (gnt_valid && in_range) begin
         ram_req_o   = 1'b1;
         ram_we_o    = sel_req.we;
         ram_be_o    = sel_req.be;
         ram_addr_o  = sel_req.addr;
         ram_wdata_o = sel_req.wdata;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_valid_q <= 1'b0;
         rsp_host_q  <= HOST_CORE;
         rsp_err_q   <= 1'b0;
         we_q        <= 1'b0;
      end else begin
         rsp_valid_q <= gnt_valid;
         if (gnt_valid) begin
            rsp_host_q <= sched_winner;
            rsp_err_q  <= ~in_range;
            we_q       <= sel_req.we;
         end
      end
   end

   // Gating with rst_i drops a response whose grant preceded a reset.
   always_comb begin
      host0_rvalid_o = rsp_valid_q && !rst_i && (rsp_host_q == HOST_CORE);
      host1_rvalid_o = rsp_valid_q && !rst_i && (rsp_host_q == HOST_LOADER);
      host0_err_o    = host0_rvalid_o && rsp_err_q;
      host1_err_o    = host1_rvalid_o && rsp_err_q;
      host0_rdata_o  = (host0_rvalid_o && !rsp_err_q && !we_q) ? ram_rdata_i : '0;
      host1_rdata_o  = (host1_rvalid_o && !rsp_err_q && !we_q) ? ram_rdata_i : '0;
   end

   a_host0_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      (host0_req_i && !host0_gnt_o) |=> host0_req_i);
   a_host1_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      (host1_req_i && !host1_gnt_o) |=> host1_req_i);

endmodule : ram_arbiter

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter : directed self-checking bench for ram_arbiter.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        h0_req = 0, h0_we = 0;
   logic [3:0]  h0_be = 0;
   logic [31:0] h0_addr = 0, h0_wdata = 0;
   logic        h1_req = 0, h1_we = 0;
   logic [3:0]  h1_be = 0;
   logic [31:0] h1_addr = 0, h1_wdata = 0;

   logic        h0_gnt, h0_rvalid, h0_err, h1_gnt, h1_rvalid, h1_err;
   logic [31:0] h0_rdata, h1_rdata;
   logic        ram_req, ram_we;
   logic [3:0]  ram_be;
   logic [31:0] ram_addr, ram_wdata;
   logic [31:0] ram_rdata = '0;

   // Second instance with MaxBurst=1 shares all inputs.
   logic        b_h0_gnt, b_h0_rvalid, b_h0_err, b_h1_gnt, b_h1_rvalid, b_h1_err;
   logic [31:0] b_h0_rdata, b_h1_rdata;
   logic        b_ram_req, b_ram_we;
   logic [3:0]  b_ram_be;
   logic [31:0] b_ram_addr, b_ram_wdata;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   ram_arbiter #(.Depth(16384), .MaxBurst(4)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .host0_req_i(h0_req), .host0_we_i(h0_we), .host0_be_i(h0_be),
      .host0_addr_i(h0_addr), .host0_wdata_i(h0_wdata),
      .host0_gnt_o(h0_gnt), .host0_rvalid_o(h0_rvalid),
      .host0_rdata_o(h0_rdata), .host0_err_o(h0_err),
      .host1_req_i(h1_req), .host1_we_i(h1_we), .host1_be_i(h1_be),
      .host1_addr_i(h1_addr), .host1_wdata_i(h1_wdata),
      .host1_gnt_o(h1_gnt), .host1_rvalid_o(h1_rvalid),
      .host1_rdata_o(h1_rdata), .host1_err_o(h1_err),
      .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_be_o(ram_be),
      .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
   );

   ram_arbiter #(.Depth(16384), .MaxBurst(1)) u_dut_b1 (
      .clk_i(clk), .rst_i(rst),
      .host0_req_i(h0_req), .host0_we_i(h0_we), .host0_be_i(h0_be),
      .host0_addr_i(h0_addr), .host0_wdata_i(h0_wdata),
      .host0_gnt_o(b_h0_gnt), .host0_rvalid_o(b_h0_rvalid),
      .host0_rdata_o(b_h0_rdata), .host0_err_o(b_h0_err),
      .host1_req_i(h1_req), .host1_we_i(h1_we), .host1_be_i(h1_be),
      .host1_addr_i(h1_addr), .host1_wdata_i(h1_wdata),
      .host1_gnt_o(b_h1_gnt), .host1_rvalid_o(b_h1_rvalid),
      .host1_rdata_o(b_h1_rdata), .host1_err_o(b_h1_err),
      .ram_req_o(b_ram_req), .ram_we_o(b_ram_we), .ram_be_o(b_ram_be),
      .ram_addr_o(b_ram_addr), .ram_wdata_o(b_ram_wdata), .ram_rdata_i(ram_rdata)
   );

   // Small 1-cycle-latency RAM behind the main instance.
   logic [31:0] mem [0:255];
   initial for (int i = 0; i < 256; i++) mem[i] = '0;
   always @(posedge clk) begin
      if (ram_req) begin
         if (ram_we) begin
            for (int b = 0; b < 4; b++)
               if (ram_be[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
         end else begin
            ram_rdata <= mem[ram_addr[9:2]];
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      h0_req = 1'b0;
      h1_req = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic exp_g0;

   initial begin
      // Reset: outputs quiet, gnt forced low even with a request present.
      rst = 1'b1;
      tick();
      h0_req = 1'b1; h0_addr = 32'h10;
      settle();
      check_val("rst_gnt0", 32'(h0_gnt), 32'd0);
      check_val("rst_ram_req", 32'(ram_req), 32'd0);
      h0_req = 1'b0;
      tick();
      rst = 1'b0;
      settle();
      check_val("rst_rvalid0", 32'(h0_rvalid), 32'd0);
      check_val("rst_rvalid1", 32'(h1_rvalid), 32'd0);
      check_val("rst_err0", 32'(h0_err), 32'd0);
      check_val("rst_rdata1", h1_rdata, 32'd0);

      // Lone host: write then read back.
      h0_req = 1'b1; h0_we = 1'b1; h0_be = 4'hF; h0_addr = 32'h10; h0_wdata = 32'hDEADBEEF;
      settle();
      check_val("wr_gnt0", 32'(h0_gnt), 32'd1);
      check_val("wr_ram_req", 32'(ram_req), 32'd1);
      check_val("wr_ram_addr", ram_addr, 32'h10);
      check_val("wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
      tick();
      h0_we = 1'b0; h0_wdata = '0;
      settle();
      check_val("rd_gnt0", 32'(h0_gnt), 32'd1);
      check_val("wr_rvalid0", 32'(h0_rvalid), 32'd1);
      check_val("wr_rdata0", h0_rdata, 32'd0);
      tick();
      h0_req = 1'b0;
      settle();
      check_val("rd_rvalid0", 32'(h0_rvalid), 32'd1);
      check_val("rd_rdata0", h0_rdata, 32'hDEADBEEF);
      check_val("rd_err0", 32'(h0_err), 32'd0);
      check_val("rd_rvalid1", 32'(h1_rvalid), 32'd0);

      // Contention: MaxBurst=4 instance and MaxBurst=1 instance side by side.
      do_reset();
      h0_req = 1'b1; h0_we = 1'b0; h0_addr = 32'h20;
      h1_req = 1'b1; h1_we = 1'b0; h1_addr = 32'h40;
      for (int i = 0; i < 9; i++) begin
         settle();
         exp_g0 = (i < 4) || (i == 8);
         check_val($sformatf("cont_gnt0_%0d", i), 32'(h0_gnt), 32'(exp_g0));
         check_val($sformatf("cont_gnt1_%0d", i), 32'(h1_gnt), 32'(!exp_g0));
         check_val($sformatf("mb1_gnt0_%0d", i), 32'(b_h0_gnt), 32'((i % 2) == 0));
         check_val($sformatf("mb1_gnt1_%0d", i), 32'(b_h1_gnt), 32'((i % 2) == 1));
         tick();
         check_val($sformatf("cont_rv0_%0d", i), 32'(h0_rvalid), 32'(exp_g0));
         check_val($sformatf("cont_rv1_%0d", i), 32'(h1_rvalid), 32'(!exp_g0));
      end
      do_reset();

      // Range boundary: last legal word, then first illegal address.
      h1_req = 1'b1; h1_we = 1'b0; h1_addr = 32'h0000_FFFC;
      settle();
      check_val("edge_ram_req", 32'(ram_req), 32'd1);
      tick();
      h1_addr = 32'h0001_0000;
      settle();
      check_val("oor_gnt1", 32'(h1_gnt), 32'd1);
      check_val("oor_ram_req", 32'(ram_req), 32'd0);
      check_val("oor_ram_addr", ram_addr, 32'd0);
      check_val("edge_err1", 32'(h1_err), 32'd0);
      tick();
      h1_req = 1'b0;
      settle();
      check_val("oor_rvalid1", 32'(h1_rvalid), 32'd1);
      check_val("oor_err1", 32'(h1_err), 32'd1);
      check_val("oor_rdata1", h1_rdata, 32'd0);
      check_val("oor_rvalid0", 32'(h0_rvalid), 32'd0);

      // Reset right after host 0's fourth grant, which had moved priority to host 1.
      do_reset();
      h0_req = 1'b1; h0_addr = 32'h10;
      for (int i = 0; i < 4; i++) begin
         settle();
         check_val($sformatf("pre_gnt0_%0d", i), 32'(h0_gnt), 32'd1);
         if (i < 3) tick();
      end
      tick();
      rst = 1'b1; h0_req = 1'b0;
      settle();
      check_val("mid_rst_rv0", 32'(h0_rvalid), 32'd0);
      tick();
      rst = 1'b0;
      settle();
      check_val("post_rst_rv0", 32'(h0_rvalid), 32'd0);
      h0_req = 1'b1; h1_req = 1'b1;
      settle();
      check_val("post_rst_gnt0", 32'(h0_gnt), 32'd1);
      check_val("post_rst_gnt1", 32'(h1_gnt), 32'd0);
      do_reset();

      // Host 1 alone for 6 grants, then host 0 joins.
      h1_req = 1'b1; h1_addr = 32'h40;
      for (int i = 0; i < 6; i++) begin
         settle();
         check_val($sformatf("lone1_gnt_%0d", i), 32'(h1_gnt), 32'd1);
         tick();
      end
      h0_req = 1'b1;
      settle();
      check_val("join_gnt0", 32'(h0_gnt), 32'd1);
      check_val("join_gnt1", 32'(h1_gnt), 32'd0);
      do_reset();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_ram_arbiter

`default_nettype wire
